// File: rtl/dll_mq_pkg.sv
// Shared opcode encodings and helpers for the multi-queue linked-list controller.
package dll_mq_pkg;

    typedef enum logic [2:0] {
        OP_POP_FRONT  = 3'b000,
        OP_POP_BACK   = 3'b001,
        OP_PUSH_FRONT = 3'b010,
        OP_PUSH_BACK  = 3'b011,
        OP_DELETE     = 3'b100
    } op_t;

    // Bit positions within op: bit1 set (with bit2 clear) means push, bit0 selects back end.
    localparam int OP_PUSH_B = 1;
    localparam int OP_BACK_B = 0;

    function automatic logic is_reserved(input logic [2:0] op);
        return op[2] & (op[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dll_mq_alloc.sv
// Shared-pool allocator: per-entry valid/owner, find-first-free, registered next pointer.
module dll_mq_alloc #(
    parameter int PTR_N = 16,
    parameter int ID_W  = 2,
    parameter int PTR_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_set_en,
    input  logic [ID_W-1:0]  i_set_id,
    input  logic             i_free_en,
    input  logic [PTR_W-1:0] i_free_ptr,
    input  logic [PTR_W-1:0] i_chk_ptr,
    input  logic [ID_W-1:0]  i_chk_id,
    output logic [PTR_W-1:0] o_alloc_ptr,
    output logic             o_full,
    output logic             o_own_ok
);
    logic [PTR_N-1:0] r_valid;
    logic [ID_W-1:0]  r_owner [PTR_N];
    logic [PTR_W-1:0] r_alloc_ptr;
    logic             r_full;
    logic [PTR_N-1:0] w_valid_nxt;
    logic [PTR_W-1:0] w_ffz;
    logic             w_all;

    always_comb begin
        w_valid_nxt = r_valid;
        if (i_set_en)
            w_valid_nxt[r_alloc_ptr] = 1'b1;
        if (i_free_en)
            w_valid_nxt[i_free_ptr] = 1'b0;
    end

    // Scan the post-update vector so the pointer is fresh for the very next acceptance.
    always_comb begin
        w_ffz = '0;
        w_all = 1'b1;
        for (int i = PTR_N - 1; i >= 0; i--) begin
            if (!w_valid_nxt[i]) begin
                w_ffz = PTR_W'(i);
                w_all = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_valid     <= '0;
            r_alloc_ptr <= '0;
            r_full      <= 1'b0;
            for (int i = 0; i < PTR_N; i++)
                r_owner[i] <= '0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_alloc_ptr <= w_ffz;
            r_full      <= w_all;
            if (i_set_en)
                r_owner[r_alloc_ptr] <= i_set_id;
        end
    end

    assign o_alloc_ptr = r_alloc_ptr;
    assign o_full      = r_full;
    assign o_own_ok    = r_valid[i_chk_ptr] & (r_owner[i_chk_ptr] == i_chk_id);
endmodule

// File: rtl/spsram.sv
// Single-port SRAM model, one registered read or one write per cycle.
module spsram #(
    parameter int W  = 8,
    parameter int N  = 16,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [N];
    logic [W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dll_mq_cntrl.sv
// Multi-queue doubly linked list controller over a shared entry pool,
// with ready/valid commands, per-command responses and O(1) mid-list delete.
module dll_mq_cntrl
    import dll_mq_pkg::*;
#(
    parameter int ID_N  = 4,
    parameter int PTR_N = 16,
    parameter int ID_W  = (ID_N  > 1) ? $clog2(ID_N)  : 1,
    parameter int PTR_W = (PTR_N > 1) ? $clog2(PTR_N) : 1,
    parameter int CNT_W = $clog2(PTR_N + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ID_W-1:0]       cmd_id,
    input  logic [PTR_W-1:0]      cmd_ptr,
    input  logic                  clear,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [PTR_W-1:0]      rsp_ptr,
    output logic                  full_r,
    output logic                  empty_r,
    output logic [ID_N-1:0]       nempty_r,
    output logic [ID_N*CNT_W-1:0] count_r,
    output logic                  busy_r
);
    typedef struct packed {
        logic [PTR_W-1:0] head;
        logic [PTR_W-1:0] tail;
    } qent_t;

    typedef struct packed {
        logic             vld;
        logic             err;
        logic [2:0]       op;
        logic [ID_W-1:0]  id;
        logic [PTR_W-1:0] ptr;
        logic             was_empty;
        logic             single;
        logic             is_head;
        logic             is_tail;
    } s1_t;

    qent_t            r_q   [ID_N];
    logic [CNT_W-1:0] r_cnt [ID_N];
    logic [CNT_W-1:0] w_cnt_nxt [ID_N];
    logic [CNT_W-1:0] w_sum;
    s1_t              r_s1;
    logic             r_rsp_err;
    logic [PTR_W-1:0] r_rsp_ptr;
    logic             r_full, r_empty;
    logic [ID_N-1:0]  r_nempty;

    logic             w_is_push, w_is_pop, w_is_del, w_back, w_err, w_acc, w_ok;
    logic             w_s1_act, w_s1_del, w_s1_push;
    qent_t            w_qe;
    logic [CNT_W-1:0] w_qcnt;
    logic [PTR_W-1:0] w_res_ptr, w_alloc_ptr;
    logic             w_alloc_full, w_own_ok;

    logic             w_nx_we, w_pv_we;
    logic [PTR_W-1:0] w_nx_addr, w_nx_wd, w_nx_rd, w_pv_addr, w_pv_wd, w_pv_rd;

    assign w_is_push = ~cmd_op[2] & cmd_op[OP_PUSH_B];
    assign w_is_pop  = ~cmd_op[2] & ~cmd_op[OP_PUSH_B];
    assign w_is_del  = (cmd_op == OP_DELETE);
    assign w_back    = cmd_op[OP_BACK_B];
    assign w_qe      = r_q[cmd_id];
    assign w_qcnt    = r_cnt[cmd_id];

    assign w_err = is_reserved(cmd_op) | (w_is_push & w_alloc_full)
                 | (w_is_pop & (w_qcnt == '0)) | (w_is_del & ~w_own_ok);

    assign w_s1_act  = r_s1.vld & ~r_s1.err;
    assign w_s1_del  = w_s1_act & (r_s1.op == OP_DELETE);
    assign w_s1_push = ~r_s1.op[2] & r_s1.op[OP_PUSH_B];

    // Same-id stall keeps the queue table coherent until stage 1 writes it back.
    assign cmd_ready = ~clear & ~(r_s1.vld & (r_s1.id == cmd_id)) & ~w_s1_del;
    assign w_acc     = cmd_valid & cmd_ready;
    assign w_ok      = w_acc & ~w_err;

    always_comb begin
        w_res_ptr = '0;
        if (w_is_push)
            w_res_ptr = w_alloc_ptr;
        else if (w_is_pop)
            w_res_ptr = w_back ? w_qe.tail : w_qe.head;
        else if (w_is_del)
            w_res_ptr = cmd_ptr;
    end

    always_comb begin
        w_nx_we = 1'b0; w_nx_addr = '0; w_nx_wd = '0;
        w_pv_we = 1'b0; w_pv_addr = '0; w_pv_wd = '0;
        if (w_s1_del && !clear) begin
            // Splice neighbours together; the head/tail side is moved in the table instead.
            w_nx_we = ~r_s1.is_head; w_nx_addr = w_pv_rd; w_nx_wd = w_nx_rd;
            w_pv_we = ~r_s1.is_tail; w_pv_addr = w_nx_rd; w_pv_wd = w_pv_rd;
        end else if (w_ok) begin
            case (cmd_op)
                OP_PUSH_BACK: if (w_qcnt != '0) begin
                    w_nx_we = 1'b1; w_nx_addr = w_qe.tail;   w_nx_wd = w_alloc_ptr;
                    w_pv_we = 1'b1; w_pv_addr = w_alloc_ptr; w_pv_wd = w_qe.tail;
                end
                OP_PUSH_FRONT: if (w_qcnt != '0) begin
                    w_pv_we = 1'b1; w_pv_addr = w_qe.head;   w_pv_wd = w_alloc_ptr;
                    w_nx_we = 1'b1; w_nx_addr = w_alloc_ptr; w_nx_wd = w_qe.head;
                end
                OP_POP_FRONT: w_nx_addr = w_qe.head;
                OP_POP_BACK:  w_pv_addr = w_qe.tail;
                OP_DELETE: begin
                    w_nx_addr = cmd_ptr;
                    w_pv_addr = cmd_ptr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < ID_N; i++)
            w_cnt_nxt[i] = r_cnt[i];
        if (w_s1_act) begin
            if (w_s1_push)
                w_cnt_nxt[r_s1.id] = r_cnt[r_s1.id] + CNT_W'(1);
            else
                w_cnt_nxt[r_s1.id] = r_cnt[r_s1.id] - CNT_W'(1);
        end
        w_sum = '0;
        for (int i = 0; i < ID_N; i++)
            w_sum = w_sum + w_cnt_nxt[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_s1      <= '0;
            r_rsp_err <= 1'b0;
            r_rsp_ptr <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_nempty  <= '0;
            for (int i = 0; i < ID_N; i++) begin
                r_q[i]   <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1.vld       <= w_acc;
            r_s1.err       <= w_err;
            r_s1.op        <= cmd_op;
            r_s1.id        <= cmd_id;
            r_s1.ptr       <= w_res_ptr;
            r_s1.was_empty <= (w_qcnt == '0);
            r_s1.single    <= (w_qcnt == CNT_W'(1));
            r_s1.is_head   <= (w_qe.head == cmd_ptr);
            r_s1.is_tail   <= (w_qe.tail == cmd_ptr);
            r_rsp_err      <= w_acc & w_err;
            r_rsp_ptr      <= w_ok ? w_res_ptr : '0;
            r_full         <= (w_sum == CNT_W'(PTR_N));
            r_empty        <= (w_sum == '0);
            for (int i = 0; i < ID_N; i++) begin
                r_cnt[i]    <= w_cnt_nxt[i];
                r_nempty[i] <= (w_cnt_nxt[i] != '0);
            end
            if (w_s1_act) begin
                case (r_s1.op)
                    OP_PUSH_FRONT, OP_PUSH_BACK: begin
                        if (r_s1.was_empty) begin
                            r_q[r_s1.id].head <= r_s1.ptr;
                            r_q[r_s1.id].tail <= r_s1.ptr;
                        end else if (r_s1.op[OP_BACK_B])
                            r_q[r_s1.id].tail <= r_s1.ptr;
                        else
                            r_q[r_s1.id].head <= r_s1.ptr;
                    end
                    OP_POP_FRONT:
                        if (r_s1.single) r_q[r_s1.id] <= '0;
                        else             r_q[r_s1.id].head <= w_nx_rd;
                    OP_POP_BACK:
                        if (r_s1.single) r_q[r_s1.id] <= '0;
                        else             r_q[r_s1.id].tail <= w_pv_rd;
                    OP_DELETE:
                        if (r_s1.is_head && r_s1.is_tail) r_q[r_s1.id] <= '0;
                        else if (r_s1.is_head)            r_q[r_s1.id].head <= w_nx_rd;
                        else if (r_s1.is_tail)            r_q[r_s1.id].tail <= w_pv_rd;
                    default: ;
                endcase
            end
        end
    end

    dll_mq_alloc #(.PTR_N(PTR_N), .ID_W(ID_W), .PTR_W(PTR_W)) u_alloc (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (clear),
        .i_set_en    (w_ok & w_is_push),
        .i_set_id    (cmd_id),
        .i_free_en   (w_s1_act & ~w_s1_push),
        .i_free_ptr  (r_s1.ptr),
        .i_chk_ptr   (cmd_ptr),
        .i_chk_id    (cmd_id),
        .o_alloc_ptr (w_alloc_ptr),
        .o_full      (w_alloc_full),
        .o_own_ok    (w_own_ok)
    );

    spsram #(.W(PTR_W), .N(PTR_N), .AW(PTR_W)) u_next (
        .i_clk(clk), .i_we(w_nx_we), .i_addr(w_nx_addr), .i_wdata(w_nx_wd), .o_rdata(w_nx_rd)
    );

    spsram #(.W(PTR_W), .N(PTR_N), .AW(PTR_W)) u_prev (
        .i_clk(clk), .i_we(w_pv_we), .i_addr(w_pv_addr), .i_wdata(w_pv_wd), .o_rdata(w_pv_rd)
    );

    for (genvar g = 0; g < ID_N; g++) begin : g_cnt
        assign count_r[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    // An in-flight response is dropped when a flush lands in its response cycle.
    assign rsp_valid = r_s1.vld & ~clear;
    assign rsp_err   = r_rsp_err;
    assign rsp_ptr   = r_rsp_ptr;
    assign full_r    = r_full;
    assign empty_r   = r_empty;
    assign nempty_r  = r_nempty;
    assign busy_r    = r_s1.vld;
endmodule

// File: tb/tb_dll_mq_cntrl.sv
// Directed bench for dll_mq_cntrl: push/pop ordering, delete, full/error, stalls, clear.
module tb_dll_mq_cntrl;
    localparam int CNT_W = 5;
    localparam logic [2:0] PF = 3'b000, PB = 3'b001, UF = 3'b010, UB = 3'b011, DL = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, clear;
    logic        cmd_ready, rsp_valid, rsp_err, full_r, empty_r, busy_r;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_id;
    logic [3:0]  cmd_ptr, rsp_ptr;
    logic [3:0]  nempty_r;
    logic [19:0] count_r;

    int n_chk = 0;
    int n_fail = 0;
    int wt;

    always #5 clk = ~clk;

    dll_mq_cntrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_ptr(cmd_ptr), .clear(clear),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_ptr(rsp_ptr),
        .full_r(full_r), .empty_r(empty_r), .nempty_r(nempty_r),
        .count_r(count_r), .busy_r(busy_r)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic int cnt(input int i);
        return int'(count_r[i*CNT_W +: CNT_W]);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one command from a negedge, wait (bounded) for ready, check the N+1 response.
    task automatic do_cmd(input string tag, input logic [2:0] op, input int id, input int ptr,
                          input int exp_err, input int exp_ptr, output int stall);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_id    = 2'(id);
        cmd_ptr   = 4'(ptr);
        #1;
        stall = 0;
        while (!cmd_ready && stall < 20) begin
            @(negedge clk);
            #1;
            stall++;
        end
        chk({tag, ".rdy"}, cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".vld"}, rsp_valid, 1);
        chk({tag, ".err"}, rsp_err, exp_err);
        chk({tag, ".ptr"}, rsp_ptr, exp_ptr);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; clear = 1'b0;
        cmd_op = '0; cmd_id = '0; cmd_ptr = '0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready", cmd_ready, 1);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.rsp_ptr", rsp_ptr, 0);
        chk("rst.full", full_r, 0);
        chk("rst.empty", empty_r, 1);
        chk("rst.nempty", nempty_r, 0);
        chk("rst.count", count_r, 0);
        chk("rst.busy", busy_r, 0);

        // id0: three push_back, then pop_front returns the oldest
        for (int i = 0; i < 3; i++)
            do_cmd("pb0", UB, 0, 0, 0, i, wt);
        chk("pb0.stall", wt, 1);
        idle(2);
        chk("pb0.count", cnt(0), 3);
        do_cmd("pf0", PF, 0, 0, 0, 0, wt);
        idle(2);

        // id1: push_front x2, pop_back returns first-pushed then second
        do_cmd("uf1a", UF, 1, 0, 0, 0, wt);
        do_cmd("uf1b", UF, 1, 0, 0, 3, wt);
        do_cmd("pb1a", PB, 1, 0, 0, 0, wt);
        do_cmd("pb1b", PB, 1, 0, 0, 3, wt);
        chk("ne1.n1", nempty_r[1], 1);
        @(negedge clk);
        chk("ne1.n2", nempty_r[1], 0);
        do_cmd("pop_empty", PF, 1, 0, 1, 0, wt);
        idle(2);

        // id2: 0,3,4 then delete the middle entry
        do_cmd("ub2a", UB, 2, 0, 0, 0, wt);
        do_cmd("ub2b", UB, 2, 0, 0, 3, wt);
        do_cmd("ub2c", UB, 2, 0, 0, 4, wt);
        do_cmd("del_mid", DL, 2, 3, 0, 3, wt);
        do_cmd("pf2a", PF, 2, 0, 0, 0, wt);
        do_cmd("pf2b", PF, 2, 0, 0, 4, wt);
        do_cmd("del_owner", DL, 3, 1, 1, 0, wt);
        do_cmd("del_free", DL, 0, 9, 1, 0, wt);
        do_cmd("del_head", DL, 0, 1, 0, 1, wt);
        do_cmd("pb0_last", PB, 0, 0, 0, 2, wt);
        do_cmd("reserved", 3'b101, 1, 0, 1, 0, wt);
        idle(2);
        chk("drain.empty", empty_r, 1);
        chk("drain.count", count_r, 0);

        // fill the pool round-robin across ids; different ids never stall
        for (int i = 0; i < 16; i++) begin
            do_cmd("fill", UB, i % 4, 0, 0, i, wt);
            chk("fill.nostall", wt, 0);
        end
        chk("full.n1", full_r, 0);
        @(negedge clk);
        chk("full.n2", full_r, 1);
        chk("full.empty", empty_r, 0);
        chk("full.count0", cnt(0), 4);
        do_cmd("push17", UB, 0, 0, 1, 0, wt);
        do_cmd("pf1a", PF, 1, 0, 0, 1, wt);
        chk("pf1a.stall", wt, 0);
        do_cmd("pf1b", PF, 1, 0, 0, 5, wt);
        chk("pf1b.stall", wt, 1);
        do_cmd("pf2", PF, 2, 0, 0, 2, wt);
        chk("pf2.stall", wt, 0);

        // clear lands in the response cycle of a DELETE
        cmd_valid = 1'b1; cmd_op = DL; cmd_id = 2'd3; cmd_ptr = 4'd3;
        #1 chk("clr.acc_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        chk("clr.rsp_n1", rsp_valid, 0);
        chk("clr.ready", cmd_ready, 0);
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clr.rsp_n2", rsp_valid, 0);
        chk("clr.empty", empty_r, 1);
        chk("clr.count", count_r, 0);
        chk("clr.nempty", nempty_r, 0);
        chk("clr.full", full_r, 0);
        chk("clr.busy", busy_r, 0);
        do_cmd("clr.push", UB, 0, 0, 0, 0, wt);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
